// File: rtl/dmem_rr_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rr_responder
//  Description : Multi-port data-memory responder. Round-robin arbitration of
//                per-core read / write / LR / SC requests onto one
//                single-ported synchronous RAM, with registered per-port read
//                and SC-status results, combinational per-port stall and one
//                LR reservation per core.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_responder #(
    parameter int    NCORES  = 2,
    parameter int    ADDRW   = 12,
    parameter string MEMFILE = ""
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NCORES-1:0]       re_packed_i,
    input  logic [NCORES-1:0]       we_packed_i,
    input  logic [ADDRW*NCORES-1:0] addr_packed_i,
    input  logic [32*NCORES-1:0]    wdata_packed_i,
    input  logic [4*NCORES-1:0]     wstrb_packed_i,
    input  logic [NCORES-1:0]       is_lr_packed_i,
    input  logic [NCORES-1:0]       is_sc_packed_i,
    output logic [32*NCORES-1:0]    rdata_packed_o,
    output logic [NCORES-1:0]       stall_packed_o
);

    localparam int c_ptr_w  = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int c_scan_w = c_ptr_w + 1;
    localparam int c_depth  = 2 ** ADDRW;

    // ------------------------------------------------------------------
    // Request unpacking
    // ------------------------------------------------------------------
    logic [NCORES-1:0] w_req;
    logic [ADDRW-1:0]  w_addr  [NCORES];
    logic [31:0]       w_wdata [NCORES];
    logic [3:0]        w_wstrb [NCORES];

    assign w_req = re_packed_i | we_packed_i;

    genvar gi;
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_unpack
            assign w_addr[gi]  = addr_packed_i[ADDRW*gi +: ADDRW];
            assign w_wdata[gi] = wdata_packed_i[32*gi +: 32];
            assign w_wstrb[gi] = wstrb_packed_i[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0]  r_ptr;
    logic [NCORES-1:0]   w_grant;
    logic [c_ptr_w-1:0]  w_gidx;
    logic                w_any;
    logic [c_scan_w-1:0] w_scan;

    // Scan ports starting at the pointer; the first requester wins
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        w_scan  = '0;
        for (int k = 0; k < NCORES; k++) begin
            w_scan = {1'b0, r_ptr} + c_scan_w'(k);
            if (w_scan >= c_scan_w'(NCORES)) begin
                w_scan = w_scan - c_scan_w'(NCORES);
            end
            if (!w_any && w_req[w_scan[c_ptr_w-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_scan[c_ptr_w-1:0];
            end
        end
        if (w_any) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Stall is purely combinational so it stays valid even during reset
    assign stall_packed_o = w_req & ~w_grant;

    // ------------------------------------------------------------------
    // Granted-operation decode (write wins over read on the same port)
    // ------------------------------------------------------------------
    logic [ADDRW-1:0] w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [3:0]       w_sel_strb;
    logic             w_do_read;
    logic             w_do_lr;
    logic             w_do_write;
    logic             w_is_sc;
    logic             w_sc_ok;
    logic             w_commit;

    logic [NCORES-1:0] r_resv_valid;
    logic [ADDRW-1:0]  r_resv_addr [NCORES];

    assign w_sel_addr  = w_addr[w_gidx];
    assign w_sel_wdata = w_wdata[w_gidx];
    assign w_sel_strb  = w_wstrb[w_gidx];

    assign w_do_write = w_any & we_packed_i[w_gidx];
    assign w_do_read  = w_any & re_packed_i[w_gidx] & ~we_packed_i[w_gidx];
    assign w_do_lr    = w_do_read & is_lr_packed_i[w_gidx];
    assign w_is_sc    = w_do_write & is_sc_packed_i[w_gidx];
    assign w_sc_ok    = r_resv_valid[w_gidx] & (r_resv_addr[w_gidx] == w_sel_addr);
    // A plain write always lands; an SC lands only with a matching reservation
    assign w_commit   = w_do_write & (~is_sc_packed_i[w_gidx] | w_sc_ok);

    // ------------------------------------------------------------------
    // Reservation update
    // ------------------------------------------------------------------
    logic [NCORES-1:0] w_resv_valid_nxt;
    logic [ADDRW-1:0]  w_resv_addr_nxt [NCORES];

    // Kill matching reservations on a committed write, consume on SC, set on LR
    always_comb begin
        w_resv_valid_nxt = r_resv_valid;
        for (int k = 0; k < NCORES; k++) begin
            w_resv_addr_nxt[k] = r_resv_addr[k];
        end
        if (w_commit) begin
            for (int k = 0; k < NCORES; k++) begin
                if (r_resv_addr[k] == w_sel_addr) begin
                    w_resv_valid_nxt[k] = 1'b0;
                end
            end
        end
        if (w_is_sc) begin
            w_resv_valid_nxt[w_gidx] = 1'b0;
        end
        if (w_do_lr) begin
            w_resv_valid_nxt[w_gidx] = 1'b1;
            w_resv_addr_nxt[w_gidx]  = w_sel_addr;
        end
    end

    // Reservation registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resv_valid <= '0;
            for (int k = 0; k < NCORES; k++) begin
                r_resv_addr[k] <= '0;
            end
        end else begin
            r_resv_valid <= w_resv_valid_nxt;
            for (int k = 0; k < NCORES; k++) begin
                r_resv_addr[k] <= w_resv_addr_nxt[k];
            end
        end
    end

    // Round-robin pointer: move just past the port that was served
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gidx == c_ptr_w'(NCORES - 1)) ? '0 : w_gidx + c_ptr_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Single-ported RAM
    // ------------------------------------------------------------------
    logic [31:0] r_mem [c_depth];
    logic [31:0] r_ram_q;

    // RAM write port; holding it in the reset domain blocks writes while
    // reset is asserted without clearing the contents
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
        end else if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel_strb[b]) begin
                    r_mem[w_sel_addr][8*b +: 8] <= w_sel_wdata[8*b +: 8];
                end
            end
        end
    end

    // RAM registered read port
    always_ff @(posedge clk_i) begin
        if (w_do_read) begin
            r_ram_q <= r_mem[w_sel_addr];
        end
    end

    // ------------------------------------------------------------------
    // Response path: the freshly produced word is steered to its port for
    // one cycle, then parked in that port's hold register
    // ------------------------------------------------------------------
    logic               r_valid;
    logic [c_ptr_w-1:0] r_port;
    logic               r_is_sc;
    logic               r_sc_fail;
    logic [31:0]        r_hold [NCORES];
    logic [31:0]        w_fresh;

    assign w_fresh = r_is_sc ? {31'b0, r_sc_fail} : r_ram_q;

    // Track which port receives a result on the following cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_port    <= '0;
            r_is_sc   <= 1'b0;
            r_sc_fail <= 1'b0;
        end else begin
            r_valid   <= w_do_read | w_is_sc;
            r_port    <= w_gidx;
            r_is_sc   <= w_is_sc;
            r_sc_fail <= ~w_sc_ok;
        end
    end

    // Keep the last result of every port until its next read/LR/SC
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NCORES; k++) begin
                r_hold[k] <= '0;
            end
        end else if (r_valid) begin
            r_hold[r_port] <= w_fresh;
        end
    end

    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_out
            assign rdata_packed_o[32*gi +: 32] =
                (r_valid && (r_port == c_ptr_w'(gi))) ? w_fresh : r_hold[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dmem_rr_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_rr_responder
//  Description : Self-checking bench for dmem_rr_responder (3 ports) with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_rr_responder;

    localparam int N  = 3;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    re, we, lr, sc;
    logic [AW*N-1:0] addr;
    logic [32*N-1:0] wdata;
    logic [4*N-1:0]  wstrb;
    logic [32*N-1:0] rdata;
    logic [N-1:0]    stall;

    always #5 clk = ~clk;

    dmem_rr_responder #(.NCORES(N), .ADDRW(AW), .MEMFILE("")) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .re_packed_i    (re),
        .we_packed_i    (we),
        .addr_packed_i  (addr),
        .wdata_packed_i (wdata),
        .wstrb_packed_i (wstrb),
        .is_lr_packed_i (lr),
        .is_sc_packed_i (sc),
        .rdata_packed_o (rdata),
        .stall_packed_o (stall)
    );

    // Reference model state
    logic [31:0] m_mem [int];
    logic [31:0] m_rd  [N];
    bit          m_rv  [N];
    int          m_ra  [N];
    int          m_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (re[idx] || we[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_stall();
        logic [N-1:0] s;
        int g;
        s = re | we;
        g = model_grant();
        if (g >= 0) s[g] = 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int k = 0; k < N; k++) begin
            m_rv[k] = 0;
            m_rd[k] = '0;
            m_ra[k] = 0;
        end
    endtask

    // Apply the currently driven requests to the model as one clock edge
    task automatic model_edge(output int g);
        int a;
        logic [31:0] d, old;
        logic [3:0] s;
        bit ok;
        g = model_grant();
        if (rst_n !== 1'b1) g = -1;
        if (g < 0) return;
        a = int'(addr[AW*g +: AW]);
        d = wdata[32*g +: 32];
        s = wstrb[4*g +: 4];
        m_ptr = (g + 1) % N;
        if (we[g]) begin
            ok = !sc[g] || (m_rv[g] && m_ra[g] == a);
            if (sc[g]) begin
                m_rd[g] = ok ? 32'd0 : 32'd1;
                m_rv[g] = 0;
            end
            if (ok) begin
                old = m_mem.exists(a) ? m_mem[a] : 32'hx;
                for (int b = 0; b < 4; b++)
                    if (s[b]) old[8*b +: 8] = d[8*b +: 8];
                m_mem[a] = old;
                for (int k = 0; k < N; k++)
                    if (m_ra[k] == a) m_rv[k] = 0;
            end
        end else if (re[g]) begin
            m_rd[g] = m_mem[a];
            if (lr[g]) begin
                m_rv[g] = 1;
                m_ra[g] = a;
            end
        end
    endtask

    task automatic tick(output int g);
        model_edge(g);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re = '0; we = '0; lr = '0; sc = '0;
        addr = '0; wdata = '0; wstrb = '0;
    endtask

    task automatic drive(input int p, input bit r, input bit w, input int a,
                         input logic [31:0] d, input logic [3:0] s,
                         input bit l, input bit c);
        re[p] = r; we[p] = w; lr[p] = l; sc[p] = c;
        addr[AW*p +: AW] = AW'(a);
        wdata[32*p +: 32] = d;
        wstrb[4*p +: 4] = s;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int g;
        idle();
        rst_n = 1'b0;
        model_reset();
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 2, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 3'b010) begin
            n_fail++; $display("FAIL reset_stall: got %b expected %b", stall, 3'b010);
        end
        n_checks++;
        if (rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        repeat (2) @(posedge clk);
        idle();
        #3;
        rst_n = 1'b1;
        tick(g);
    endtask

    task automatic test_single();
        int g;
        idle();
        drive(0, 0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0);
        #1;
        n_checks++;
        if (stall !== 3'b000) begin
            n_fail++; $display("FAIL single_wr_stall: got %b expected 000", stall);
        end
        tick(g);
        drive(0, 1, 0, 5, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rdata[31:0] !== m_rd[0]) begin
            n_fail++; $display("FAIL single_pre_read: got %h expected %h", rdata[31:0], m_rd[0]);
        end
        tick(g);
        idle();
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_read: got %h expected DEADBEEF", rdata[31:0]);
        end
        tick(g);
        n_checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_hold: got %h expected DEADBEEF", rdata[31:0]);
        end
    endtask

    task automatic test_strobe();
        int g;
        idle(); drive(0, 0, 1, 9, 32'h11223344, 4'hF, 0, 0); tick(g);
        idle(); drive(0, 0, 1, 9, 32'hAABBCCDD, 4'b0100, 0, 0);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL strobe_write_no_rdata: got %h expected DEADBEEF", rdata[31:0]);
        end
        tick(g);
        idle(); drive(0, 1, 0, 9, 0, 0, 0, 0); tick(g);
        idle();
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h11BB3344 || rdata[31:0] !== m_rd[0]) begin
            n_fail++; $display("FAIL strobe_read: got %h expected 11BB3344", rdata[31:0]);
        end
    endtask

    task automatic test_contention();
        int g;
        logic [N-1:0] tbl [3];
        logic [31:0] want [N];
        tbl[0] = 3'b110; tbl[1] = 3'b100; tbl[2] = 3'b000;
        idle(); drive(2, 0, 1, 100, 32'h00000100, 4'hF, 0, 0); tick(g);
        idle();
        drive(0, 1, 0, 5, 0, 0, 0, 0);
        drive(1, 1, 0, 9, 0, 0, 0, 0);
        drive(2, 1, 0, 100, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (stall !== tbl[c] || stall !== exp_stall()) begin
                n_fail++; $display("FAIL contention_stall[%0d]: got %b expected %b", c, stall, tbl[c]);
            end
            for (int p = 0; p < N; p++) begin
                n_checks++;
                if (rdata[32*p +: 32] !== m_rd[p]) begin
                    n_fail++; $display("FAIL contention_rdata[%0d][%0d]: got %h expected %h",
                                       c, p, rdata[32*p +: 32], m_rd[p]);
                end
            end
            tick(g);
            if (g >= 0) drive(g, 0, 0, 0, 0, 0, 0, 0);
        end
        #1;
        want[0] = 32'hDEADBEEF; want[1] = 32'h11BB3344; want[2] = 32'h00000100;
        for (int p = 0; p < N; p++) begin
            n_checks++;
            if (rdata[32*p +: 32] !== want[p]) begin
                n_fail++; $display("FAIL contention_final[%0d]: got %h expected %h",
                                   p, rdata[32*p +: 32], want[p]);
            end
        end
        // Pointer wrapped back to port 0
        drive(0, 1, 0, 5, 0, 0, 0, 0);
        drive(1, 1, 0, 9, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 3'b010) begin
            n_fail++; $display("FAIL contention_ptr_wrap: got %b expected 010", stall);
        end
        tick(g);
        idle(); drive(1, 1, 0, 9, 0, 0, 0, 0); tick(g);
        idle(); tick(g);
    endtask

    task automatic test_lrsc_success();
        int g;
        idle(); drive(0, 0, 1, 8, 32'h12345678, 4'hF, 0, 0); tick(g);
        idle(); drive(0, 1, 0, 8, 0, 0, 1, 0); tick(g);
        idle(); drive(0, 0, 1, 8, 32'h00000077, 4'hF, 0, 1); tick(g);
        idle(); drive(0, 1, 0, 8, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'd0) begin
            n_fail++; $display("FAIL lrsc_ok_status: got %h expected 0", rdata[31:0]);
        end
        tick(g);
        idle(); drive(0, 0, 1, 8, 32'h00000099, 4'hF, 0, 1);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h77) begin
            n_fail++; $display("FAIL lrsc_ok_data: got %h expected 77", rdata[31:0]);
        end
        tick(g);
        idle(); drive(0, 1, 0, 8, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'd1) begin
            n_fail++; $display("FAIL lrsc_second_status: got %h expected 1", rdata[31:0]);
        end
        tick(g);
        idle();
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h77) begin
            n_fail++; $display("FAIL lrsc_second_nowrite: got %h expected 77", rdata[31:0]);
        end
    endtask

    task automatic test_lrsc_kill();
        int g;
        idle(); drive(1, 1, 0, 8, 0, 0, 1, 0); tick(g);
        idle(); drive(0, 1, 0, 8, 0, 0, 1, 0); tick(g);
        idle(); drive(1, 0, 1, 8, 32'h00000055, 4'hF, 0, 0); tick(g);
        idle(); drive(0, 0, 1, 8, 32'h00000077, 4'hF, 0, 1); tick(g);
        idle(); drive(1, 0, 1, 8, 32'h00000099, 4'hF, 0, 1);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'd1) begin
            n_fail++; $display("FAIL kill_sc0_status: got %h expected 1", rdata[31:0]);
        end
        tick(g);
        idle(); drive(0, 1, 0, 8, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rdata[63:32] !== 32'd1) begin
            n_fail++; $display("FAIL kill_sc1_status: got %h expected 1", rdata[63:32]);
        end
        tick(g);
        idle();
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h55 || m_mem[8] !== 32'h55) begin
            n_fail++; $display("FAIL kill_data: got %h expected 55", rdata[31:0]);
        end
    endtask

    task automatic test_random();
        int g;
        bit pend [N];
        for (int a = 0; a < 4; a++) begin
            idle(); drive(0, 0, 1, a, $urandom, 4'hF, 0, 0); tick(g);
        end
        idle();
        for (int p = 0; p < N; p++) pend[p] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < N; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        int k;
                        bit r, w, l, c;
                        k = $urandom_range(0, 4);
                        r = (k == 0) || (k == 2) || (k == 4);
                        w = (k == 1) || (k == 3) || (k == 4);
                        l = (k == 2) || ((k == 4) && $urandom_range(0, 1) == 1);
                        c = (k == 3) || ((k == 4) && $urandom_range(0, 1) == 1);
                        drive(p, r, w, $urandom_range(0, 3), $urandom,
                              4'($urandom_range(0, 15)), l, c);
                        pend[p] = 1;
                    end else begin
                        drive(p, 0, 0, 0, 0, 0, 0, 0);
                    end
                end
            end
            #1;
            n_checks++;
            if (stall !== exp_stall()) begin
                n_fail++; $display("FAIL rand_stall[%0d]: got %b expected %b", cyc, stall, exp_stall());
            end
            for (int p = 0; p < N; p++) begin
                n_checks++;
                if (rdata[32*p +: 32] !== m_rd[p]) begin
                    n_fail++; $display("FAIL rand_rdata[%0d][%0d]: got %h expected %h",
                                       cyc, p, rdata[32*p +: 32], m_rd[p]);
                end
            end
            tick(g);
            if (g >= 0) pend[g] = 0;
        end
        idle();
        tick(g);
    endtask

    task automatic test_reset_mid();
        int g;
        idle(); drive(0, 0, 1, 20, 32'hCAFE0000, 4'hF, 0, 0); tick(g);
        idle(); drive(2, 0, 1, 30, 32'h00003030, 4'hF, 0, 0); tick(g);
        idle(); drive(2, 1, 0, 30, 0, 0, 1, 0); tick(g);
        idle(); drive(0, 1, 0, 20, 0, 0, 0, 0); tick(g);
        idle();
        drive(0, 1, 0, 20, 0, 0, 0, 0);
        drive(1, 1, 0, 30, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 3'b001) begin
            n_fail++; $display("FAIL rmid_pre_stall: got %b expected 001", stall);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (rdata !== '0) begin
            n_fail++; $display("FAIL rmid_rdata_clear: got %h expected 0", rdata);
        end
        n_checks++;
        if (stall !== 3'b010) begin
            n_fail++; $display("FAIL rmid_reset_stall: got %b expected 010", stall);
        end
        idle(); drive(1, 0, 1, 20, 32'h00000BAD, 4'hF, 0, 0);
        #1;
        n_checks++;
        if (stall !== 3'b000) begin
            n_fail++; $display("FAIL rmid_reset_wr_stall: got %b expected 000", stall);
        end
        @(posedge clk);
        #1;
        drive(0, 1, 0, 20, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 3'b010) begin
            n_fail++; $display("FAIL rmid_release_stall: got %b expected 010", stall);
        end
        #1;
        rst_n = 1'b1;
        tick(g);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'hCAFE0000 || rdata[31:0] !== m_rd[0]) begin
            n_fail++; $display("FAIL rmid_no_write_in_reset: got %h expected CAFE0000", rdata[31:0]);
        end
        n_checks++;
        if (stall !== 3'b000) begin
            n_fail++; $display("FAIL rmid_port1_turn: got %b expected 000", stall);
        end
        tick(g);
        idle(); drive(2, 0, 1, 30, 32'h00009999, 4'hF, 0, 1); tick(g);
        idle(); drive(0, 1, 0, 30, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rdata[95:64] !== 32'd1) begin
            n_fail++; $display("FAIL rmid_resv_cleared: got %h expected 1", rdata[95:64]);
        end
        tick(g);
        idle(); drive(0, 1, 0, 20, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h00003030) begin
            n_fail++; $display("FAIL rmid_sc_nowrite: got %h expected 3030", rdata[31:0]);
        end
        tick(g);
        idle();
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h00000BAD) begin
            n_fail++; $display("FAIL rmid_post_write: got %h expected BAD", rdata[31:0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_strobe();
        test_contention();
        test_lrsc_success();
        test_lrsc_kill();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
